// File: rtl/omi_mem_responder_if.sv
// omi_mem_responder_if
// Request/response bundle between a cache controller (master) and the
// memory responder (slave). Signal names keep the responder's view:
// i_mem_* flow from the cache into the memory, o_mem_* flow back.
//
// Handshake: the slave raises o_mem_rdy when idle. A request transfers
// on a rising edge where i_mem_req=1 and o_mem_rdy=1; all i_mem_* fields
// are sampled on that edge. i_mem_req while o_mem_rdy=0 is ignored.
// Read beats are pushed with o_mem_valid and have no back-pressure, so
// the master must take every beat in the cycle it is presented.
interface omi_mem_responder_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                    i_mem_req;
  logic [ADDR_WIDTH-1:0]   i_mem_addr;
  logic                    i_mem_wen;
  logic [DATA_WIDTH/8-1:0] i_mem_ben;
  logic [DATA_WIDTH-1:0]   i_mem_data;
  logic [7:0]              i_mem_len;
  logic                    o_mem_rdy;
  logic                    o_mem_valid;
  logic [DATA_WIDTH-1:0]   o_mem_data;
  logic                    o_mem_err;

  modport slave (
    input  i_mem_req, i_mem_addr, i_mem_wen, i_mem_ben, i_mem_data, i_mem_len,
    output o_mem_rdy, o_mem_valid, o_mem_data, o_mem_err
  );

  modport master (
    output i_mem_req, i_mem_addr, i_mem_wen, i_mem_ben, i_mem_data, i_mem_len,
    input  o_mem_rdy, o_mem_valid, o_mem_data, o_mem_err
  );
endinterface

// File: rtl/omi_mem_responder.sv
// omi_mem_responder
// Word-addressed RAM behind the OMI request interface. Serves one request
// at a time: single-beat byte-enabled writes, or read bursts of len+1
// beats whose word index wraps at the end of the RAM.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (RAM contents are kept)
//   bus        omi_mem_responder_if.slave: request fields in, rdy/valid/
//              data/err out (all outputs registered)
//   dbg_state  current FSM state (IDLE=0, WR_WAIT=1, RD_WAIT=2, RD_BURST=3)
module omi_mem_responder #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  omi_mem_responder_if.slave  bus,
  output logic [1:0]          dbg_state
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int WB    = $clog2(NB);
  localparam int IW    = ADDR_WIDTH - WB;
  localparam int DEPTH = 1 << IW;

  // Counters hold latency-1 so that a terminal count of zero lands the
  // event exactly LATENCY edges after acceptance.
  localparam logic [3:0] RD_LAT_M1 = 4'(READ_LATENCY - 1);
  localparam logic [3:0] WR_LAT_M1 = 4'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_WAIT  = 2'd1,
    RD_WAIT  = 2'd2,
    RD_BURST = 2'd3
  } state_t;

  state_t                state;
  logic                  rdy_q;
  logic                  valid_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [3:0]            lat_cnt;
  logic [7:0]            beats_left;
  logic [IW-1:0]         ptr;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IW-1:0] req_idx;
  logic          accept;
  logic          wr_en;
  logic          unused_addr_lsbs;

  // Byte-offset bits are dropped: every access is word aligned.
  assign req_idx          = bus.i_mem_addr[ADDR_WIDTH-1:WB];
  assign unused_addr_lsbs = ^bus.i_mem_addr[WB-1:0];

  // rdy_q is only ever high in IDLE, so it alone qualifies acceptance.
  // Reset blocks acceptance so a simultaneous write never commits.
  assign accept = rdy_q && bus.i_mem_req && !reset;
  assign wr_en  = accept && bus.i_mem_wen;

  // Writes commit on the acceptance edge; the RAM is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (bus.i_mem_ben[k]) begin
          mem[req_idx][8*k +: 8] <= bus.i_mem_data[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rdy_q      <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
      lat_cnt    <= '0;
      beats_left <= '0;
      ptr        <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            rdy_q      <= 1'b0;
            ptr        <= req_idx;
            beats_left <= bus.i_mem_len;
            if (bus.i_mem_wen) begin
              state   <= WR_WAIT;
              lat_cnt <= WR_LAT_M1;
              err_q   <= (bus.i_mem_len != 8'd0);
            end else begin
              state   <= RD_WAIT;
              lat_cnt <= RD_LAT_M1;
            end
          end else begin
            // Also the path that raises rdy on the first edge after reset.
            rdy_q <= 1'b1;
          end
        end
        WR_WAIT: begin
          if (lat_cnt == 4'd0) begin
            state <= IDLE;
            rdy_q <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RD_WAIT: begin
          if (lat_cnt == 4'd0) begin
            state   <= RD_BURST;
            valid_q <= 1'b1;
            data_q  <= mem[ptr];
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RD_BURST: begin
          if (beats_left == 8'd0) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            rdy_q   <= 1'b1;
          end else begin
            // ptr is IW bits wide, so the increment wraps at DEPTH.
            data_q     <= mem[ptr + IW'(1)];
            ptr        <= ptr + IW'(1);
            beats_left <= beats_left - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_mem_rdy   = rdy_q;
  assign bus.o_mem_valid = valid_q;
  assign bus.o_mem_data  = data_q;
  assign bus.o_mem_err   = err_q;
  assign dbg_state       = state;
endmodule

// File: tb/tb_omi_mem_responder.sv
// tb_omi_mem_responder
// Drives directed and random requests into omi_mem_responder and compares
// every output, every cycle, against a transaction-level model: a word
// array plus a queue of upcoming (valid, data) output slots and a count of
// cycles rdy must stay low.
module tb_omi_mem_responder;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int RL    = 2;
  localparam int WL    = 1;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << (AW - $clog2(NB));

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  omi_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  omi_mem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] mdl_mem [DEPTH];
  logic [DW:0]   exp_q[$];        // {valid, data} for upcoming cycles
  int            busy = 0;        // cycles rdy must still be low
  logic          started   = 1'b0;
  logic          exp_rdy   = 1'b0;
  logic          exp_valid = 1'b0;
  logic          exp_err   = 1'b0;
  logic [DW-1:0] exp_data  = '0;

  always @(posedge clk) begin : model
    int          idx;
    logic        take;
    logic [DW:0] slot;
    if (reset) begin
      started   = 1'b1;
      busy      = 0;
      exp_q.delete();
      exp_rdy   = 1'b0;
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_err   = 1'b0;
    end else begin
      take    = exp_rdy && bus.i_mem_req;
      exp_err = 1'b0;
      if (take) begin
        idx = int'(bus.i_mem_addr) / NB;
        if (bus.i_mem_wen) begin
          for (int k = 0; k < NB; k++)
            if (bus.i_mem_ben[k]) mdl_mem[idx][8*k +: 8] = bus.i_mem_data[8*k +: 8];
          busy    = WL;
          exp_err = (bus.i_mem_len != 8'd0);
        end else begin
          busy = RL + int'(bus.i_mem_len) + 1;
          repeat (RL) exp_q.push_back('0);
          for (int i = 0; i <= int'(bus.i_mem_len); i++)
            exp_q.push_back({1'b1, mdl_mem[(idx + i) % DEPTH]});
        end
      end
      if (busy > 0) begin
        exp_rdy = 1'b0;
        busy--;
      end else begin
        exp_rdy = 1'b1;
      end
      if (exp_q.size() > 0) begin
        slot      = exp_q.pop_front();
        exp_valid = slot[DW];
        exp_data  = slot[DW-1:0];
      end else begin
        exp_valid = 1'b0;
        exp_data  = '0;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("cyc_rdy",   DW'(bus.o_mem_rdy),   DW'(exp_rdy));
      chk("cyc_valid", DW'(bus.o_mem_valid), DW'(exp_valid));
      chk("cyc_data",  bus.o_mem_data,       exp_data);
      chk("cyc_err",   DW'(bus.o_mem_err),   DW'(exp_err));
    end
  end

  // ---------------- driver tasks ----------------
  int            last_wait;
  int            first_wait;
  logic          rdy_during;
  logic [DW-1:0] got_q[$];

  // Called at a negedge; holds the request until accepted and returns at
  // the negedge right after the acceptance edge with req dropped.
  task automatic do_req(input logic [AW-1:0] a, input logic w, input logic [NB-1:0] b,
                        input logic [DW-1:0] d, input logic [7:0] l);
    int n = 0;
    bus.i_mem_req  = 1'b1;
    bus.i_mem_addr = a;
    bus.i_mem_wen  = w;
    bus.i_mem_ben  = b;
    bus.i_mem_data = d;
    bus.i_mem_len  = l;
    while (!bus.o_mem_rdy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      fails++;
      $display("FAIL req_timeout: got no rdy within %0d cycles required rdy=1", n);
    end
    @(negedge clk);
    bus.i_mem_req = 1'b0;
    last_wait = n;
  endtask

  // Collects nb read beats; returns at the negedge after the last beat.
  task automatic collect(input int nb);
    int cyc = 0;
    got_q.delete();
    first_wait = -1;
    rdy_during = 1'b0;
    while (got_q.size() < nb && cyc < 400) begin
      if (bus.o_mem_valid) begin
        if (first_wait < 0) first_wait = cyc;
        got_q.push_back(bus.o_mem_data);
        rdy_during = rdy_during | bus.o_mem_rdy;
      end
      @(negedge clk);
      cyc++;
    end
    if (got_q.size() < nb) begin
      checks++;
      fails++;
      $display("FAIL beat_timeout: got %0d beats required %0d", got_q.size(), nb);
      while (got_q.size() < nb) got_q.push_back('x);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.i_mem_req  = 1'b0;
    bus.i_mem_addr = '0;
    bus.i_mem_wen  = 1'b0;
    bus.i_mem_ben  = '0;
    bus.i_mem_data = '0;
    bus.i_mem_len  = '0;

    // Reset and release.
    repeat (3) @(negedge clk);
    chk("reset_rdy", DW'(bus.o_mem_rdy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_rdy",   DW'(bus.o_mem_rdy),   32'd1);
    chk("rel_valid", DW'(bus.o_mem_valid), 32'd0);
    chk("rel_data",  bus.o_mem_data,       32'd0);
    chk("rel_err",   DW'(bus.o_mem_err),   32'd0);

    // Give every word a known value.
    for (int i = 0; i < DEPTH; i++) do_req(AW'(i * NB), 1'b1, '1, $urandom, 8'd0);

    // Full write then read-back with latency check.
    do_req(10'h010, 1'b1, 4'hF, 32'hDEADBEEF, 8'd0);
    chk("wr_rdy_low", DW'(bus.o_mem_rdy), 32'd0);
    @(negedge clk);
    chk("wr_rdy_back", DW'(bus.o_mem_rdy), 32'd1);
    do_req(10'h010, 1'b0, 4'h0, 32'h0, 8'd0);
    collect(1);
    chk("rd_data", got_q[0], 32'hDEADBEEF);
    chk("rd_latency", DW'(first_wait), 32'd2);
    chk("rd_rdy_back", DW'(bus.o_mem_rdy), 32'd1);

    // Byte-enable merge.
    do_req(10'h010, 1'b1, 4'b0101, 32'h11223344, 8'd0);
    do_req(10'h010, 1'b0, 4'h0, 32'h0, 8'd0);
    collect(1);
    chk("merge_data", got_q[0], 32'hDE22BE44);

    // Burst wrapping past the last word.
    do_req(10'h3FC, 1'b1, 4'hF, 32'hAAAA0001, 8'd0);
    do_req(10'h000, 1'b1, 4'hF, 32'hBBBB0002, 8'd0);
    do_req(10'h004, 1'b1, 4'hF, 32'hCCCC0003, 8'd0);
    do_req(10'h3FC, 1'b0, 4'h0, 32'h0, 8'd2);
    collect(3);
    chk("wrap_beat0", got_q[0], 32'hAAAA0001);
    chk("wrap_beat1", got_q[1], 32'hBBBB0002);
    chk("wrap_beat2", got_q[2], 32'hCCCC0003);
    chk("wrap_rdy_low", DW'(rdy_during), 32'd0);

    // Write request held high during a burst covering its own address.
    do_req(10'h020, 1'b1, 4'hF, 32'h55555555, 8'd0);
    do_req(10'h01C, 1'b0, 4'h0, 32'h0, 8'd3);
    fork
      collect(4);
      do_req(10'h020, 1'b1, 4'hF, 32'hCAFEF00D, 8'd0);
    join
    chk("held_burst_data", got_q[1], 32'h55555555);
    chk("held_accept_wait", DW'(last_wait), 32'd6);
    do_req(10'h020, 1'b0, 4'h0, 32'h0, 8'd0);
    collect(1);
    chk("held_write_data", got_q[0], 32'hCAFEF00D);

    // Write with non-zero len: error pulse, single word written.
    do_req(10'h040, 1'b1, 4'hF, 32'h0BADF00D, 8'd3);
    chk("err_pulse", DW'(bus.o_mem_err), 32'd1);
    @(negedge clk);
    chk("err_clear", DW'(bus.o_mem_err), 32'd0);
    do_req(10'h040, 1'b0, 4'h0, 32'h0, 8'd1);
    collect(2);
    chk("err_word", got_q[0], 32'h0BADF00D);
    chk("err_next_word", got_q[1], mdl_mem[17]);

    // Reset during beat 1 of a burst.
    do_req(10'h080, 1'b0, 4'h0, 32'h0, 8'd3);
    collect(1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_valid", DW'(bus.o_mem_valid), 32'd0);
    chk("abort_rdy",   DW'(bus.o_mem_rdy),   32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_rdy_back", DW'(bus.o_mem_rdy), 32'd1);

    // Random traffic with random gaps (gap 0 = back-to-back).
    for (int t = 0; t < 300; t++) begin
      logic       w;
      logic [7:0] l;
      w = 1'($urandom_range(0, 1));
      if (w) l = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      else   l = 8'($urandom_range(0, 7));
      do_req(AW'($urandom_range(0, (1 << AW) - 1)), w, NB'($urandom_range(0, 15)), $urandom, l);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/omi_mem_responder.md
Name: omi_mem_responder

Overview:
- Memory-side responder for the OMI request interface driven by the cache controller (o_mem_req/addr/wen/ben/data/len out, i_mem_rdy/valid/data back).
- Holds a word-addressed RAM. Accepts one request at a time: single-beat byte-enabled writes, or read bursts of len+1 beats.
- Serves as the backing store in cache simulations and as the on-chip scratch memory on FPGA builds.
- Port directions are mirrored from the cache side: the cache's o_mem_* become i_mem_* here, and vice versa.

Parameters:
- ADDR_WIDTH, 10: byte address width.
- DATA_WIDTH, 32: data width; must be a multiple of 8 and at least 16.
- READ_LATENCY, 2: cycles from request acceptance to the first read beat; legal range 1..15.
- WRITE_LATENCY, 1: cycles from request acceptance until o_mem_rdy reasserts after a write; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- i_mem_req  in  1  request strobe; accepted only when o_mem_rdy=1.
- i_mem_addr  in  ADDR_WIDTH  byte address.
- i_mem_wen  in  1  1=write, 0=read.
- i_mem_ben  in  DATA_WIDTH/8  write byte enables; bit k enables byte k.
- i_mem_data  in  DATA_WIDTH  write data.
- i_mem_len  in  8  read beats minus 1; must be 0 for writes.
- o_mem_rdy  out  1  idle; a request may be accepted.
- o_mem_valid  out  1  read beat valid.
- o_mem_data  out  DATA_WIDTH  read beat data; 0 whenever o_mem_valid=0.
- o_mem_err  out  1  one-cycle pulse when a write is accepted with len!=0.

Behaviour:
- Derived constants:
  - WB = log2(DATA_WIDTH/8).
  - Word index = addr[ADDR_WIDTH-1:WB]; addr[WB-1:0] is ignored (unaligned bits dropped).
  - DEPTH = 2^(ADDR_WIDTH-WB).
- Reset (reset=1 at a clock edge):
  - Outputs: o_mem_rdy=0, o_mem_valid=0, o_mem_data=0, o_mem_err=0.
  - Internal: state=IDLE, counters cleared.
  - RAM contents are not cleared.
  - First edge with reset=0: o_mem_rdy goes to 1.
  - Reset asserted mid-burst or mid-write aborts the operation immediately. A write already committed stays committed.
- Acceptance:
  - A request is accepted at an edge where i_mem_req=1 and o_mem_rdy=1.
  - addr, wen, ben, data and len are latched at that edge.
  - o_mem_rdy is 0 from the next cycle until the operation completes.
  - i_mem_req while o_mem_rdy=0 is ignored and has no side effects.
- States:
  - IDLE: rdy=1.
    - req & wen: go to WR_WAIT; commit the write on the same edge.
    - req & !wen: go to RD_WAIT.
  - WR_WAIT: count WRITE_LATENCY cycles, then go to IDLE with rdy=1.
    - With WRITE_LATENCY=1, rdy is low for exactly 1 cycle.
  - RD_WAIT: count READ_LATENCY cycles. The first beat (valid=1) appears exactly READ_LATENCY cycles after the acceptance edge, then go to RD_BURST.
  - RD_BURST: one beat per cycle, back-to-back; valid is never deasserted mid-burst.
    - Beat i returns RAM[(idx+i) mod DEPTH], i.e. the word index wraps at DEPTH.
    - After beat len (len+1 beats total), valid=0 and rdy=1 in the next cycle; back to IDLE.
- Write merge: for each byte k with ben[k]=1, RAM[idx].byte[k] <= data.byte[k]. Other bytes are unchanged. ben=0 is a legal no-op write.
- Write with len!=0:
  - o_mem_err pulses in the cycle after acceptance.
  - Exactly one beat is written; len is otherwise ignored.
- Ordering:
  - A read accepted after a write completes returns the written data (no stale read).
  - Back-to-back operations are allowed: a new req in the first cycle rdy=1 is accepted.
- Minimum spacing: the fastest read is len=0 with READ_LATENCY=1, which keeps rdy low for 2 cycles.
- Simultaneous reset and req: reset wins and the request is not accepted.

Test Plan:
- Reset → o_mem_rdy=0 while reset=1. Release reset → rdy=1 on the next edge; valid=0, data=0, err=0.
- Write addr=0x010, ben=4'hF, data=32'hDEADBEEF → rdy low for 1 cycle. Then read addr=0x010, len=0 → valid for 1 cycle, 2 cycles after acceptance, data=DEADBEEF; rdy back the next cycle.
- Write addr=0x010, ben=4'b0101, data=32'h11223344 over DEADBEEF → read returns DE22BE44.
- Preload words 0x3FC, 0x000 and 0x004 with A, B and C. Read addr=0x3FC, len=2 → 3 consecutive beats A, B, C (wrap verified); rdy stays 0 throughout.
- During a read burst, hold i_mem_req=1 with wen=1 → no write occurs, burst data unaffected. The request is accepted only in the first rdy=1 cycle.
- Write with len=3 → err pulse 1 cycle after acceptance; only one word changes. Separately, assert reset mid-burst at beat 1 → valid=0 and rdy=0 next cycle; rdy=1 after reset release.
